// File: rtl/wavetable_recorder.sv
// wavetable_recorder: serial-to-parallel 32-bit wavetable capture for the Rec_WT path (optional WT_REC_MAJORITY_EN)
module wavetable_recorder #(
    parameter int DIV = 25000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Record,
    input  logic        BitIn,
    output logic [31:0] Rec_WT,
    output logic        Valid,
    output logic        Done,
    output logic        Busy,
    output logic [5:0]  BitIdx
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] L_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] L_SAMP = CW'(DIV / 2 - 1);
    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;
    state_t       r_state;
    logic         r_rec_m, r_rec_s, r_rec_q, r_bit_m, r_bit_s;
    logic [1:0]   r_warm;
    logic         r_arm;
    logic [CW-1:0] r_cnt;
    logic [31:0]  r_sh, r_wt;
    logic [5:0]   r_idx;
    logic         r_valid, r_done, r_busy;
    logic         w_rise, w_shift, w_bit;
    // Synchronisers; a rise only counts once Record has been seen low after reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rec_m <= 1'b0;
            r_rec_s <= 1'b0;
            r_rec_q <= 1'b0;
            r_bit_m <= 1'b0;
            r_bit_s <= 1'b0;
            r_warm  <= 2'b00;
            r_arm   <= 1'b0;
        end else begin
            r_rec_m <= Record;
            r_rec_s <= r_rec_m;
            r_rec_q <= r_rec_s;
            r_bit_m <= BitIn;
            r_bit_s <= r_bit_m;
            r_warm  <= {r_warm[0], 1'b1};
            r_arm   <= r_arm | (r_warm[1] & ~r_rec_s);
        end
    end
    assign w_rise = r_rec_s & ~r_rec_q & r_arm;
`ifdef WT_REC_MAJORITY_EN
    localparam logic [CW-1:0] L_PRE  = CW'(DIV / 2 - 2);
    localparam logic [CW-1:0] L_POST = CW'(DIV / 2);
    logic r_m0, r_m1;
    // Hold the two early votes around the bit centre
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_m0 <= 1'b0;
            r_m1 <= 1'b0;
        end else begin
            r_m0 <= (r_cnt == L_PRE) ? r_bit_s : r_m0;
            r_m1 <= (r_cnt == L_SAMP) ? r_bit_s : r_m1;
        end
    end
    assign w_shift = (r_cnt == L_POST);
    assign w_bit   = (r_m0 & r_m1) | (r_m0 & r_bit_s) | (r_m1 & r_bit_s);
`else
    assign w_shift = (r_cnt == L_SAMP);
    assign w_bit   = r_bit_s;
`endif
    // Capture FSM; abort beats shift and completion, Rec_WT only moves in DONE
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sh    <= '0;
            r_idx   <= '0;
            r_wt    <= 32'hFF00FF00;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (w_rise) begin
                        r_state <= S_CAPTURE;
                        r_cnt   <= '0;
                        r_sh    <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (!r_rec_s) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_sh    <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= (r_cnt == L_LAST) ? '0 : r_cnt + CW'(1);
                        if (w_shift) begin
                            r_sh  <= {r_sh[30:0], w_bit};
                            r_idx <= r_idx + 6'd1;
                        end
                        if (r_cnt == L_LAST && r_idx == 6'd32) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_wt    <= r_sh;
                    r_valid <= 1'b1;
                    r_done  <= 1'b0;
                    r_idx   <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end
    assign Rec_WT = r_wt;
    assign Valid  = r_valid;
    assign Done   = r_done;
    assign Busy   = r_busy;
    assign BitIdx = r_idx;
endmodule

// File: doc/wavetable_recorder.md
# wavetable_recorder

Captures a user-played 32-bit wavetable from a serial bit input and presents it as a parallel word for the note player's recorded-table path (`Rec_WT`). It is the writer side of that interface, and it sits between the board input (switch or button bit) and the note/synth block.

- Recording starts on a rising edge of `Record`.
- The block samples `BitIn` once per bit period, MSB first, for 32 periods.
- On completion it atomically updates `Rec_WT`.

## Interface
Parameters:
- `DIV`, default 25000: clock cycles per captured bit. Legal range is 4 to 2^20, and `DIV` must be even.

Ports:
- `CLK`  in  1  system clock; all logic is on the rising edge.
- `RST`  in  1  reset; asynchronous and active-high.
- `Record`  in  1  arm/hold level, asynchronous to `CLK`. A rise starts a capture; a fall mid-capture aborts it.
- `BitIn`  in  1  serial wavetable bit, asynchronous to `CLK`.
- `Rec_WT`  out  32  last completed recorded wavetable; reset value 32'hFF00FF00.
- `Valid`  out  1  high once any capture has completed since reset; reset value 0.
- `Done`  out  1  one-cycle pulse when `Rec_WT` updates; reset value 0.
- `Busy`  out  1  high while in CAPTURE; reset value 0.
- `BitIdx`  out  6  number of bits captured so far in the current capture (0..32); reset value 0.

## Operation
- **Synchronisers:** `Record` and `BitIn` each pass through a 2-flop synchroniser, giving `rec_s` and `bit_s`. `rec_q` is `rec_s` delayed by one cycle. A rise is `rec_s & ~rec_q`.
- **FSM states:** IDLE, CAPTURE, DONE.
- **IDLE:**
  - On a detected rise, the FSM moves to CAPTURE.
  - The entry clears `cnt` (width clog2(`DIV`)), `BitIdx` and the internal shift register `sh[31:0]`.
  - `Record` already high out of reset does not start a capture; a new rise is needed.
- **CAPTURE, counting:** `cnt` counts 0..`DIV`-1 and wraps to 0.
- **CAPTURE, sampling:**
  - When `cnt == DIV/2-1`, the block shifts: `sh <= {sh[30:0], bit_s}`.
  - `BitIdx` increments in the same cycle.
  - The first captured bit therefore ends in bit 31.
- **CAPTURE, end of capture:** when `cnt == DIV-1` and `BitIdx == 32`, the FSM moves to DONE.
- **CAPTURE, abort:**
  - If `rec_s == 0` in any CAPTURE cycle, the FSM moves to IDLE.
  - `sh` is discarded, `BitIdx` is cleared, and `Rec_WT`, `Valid` and `Done` are untouched.
  - Abort has priority over shift and over completion in the same cycle.
- **DONE:**
  - Lasts one cycle: `Rec_WT <= sh`, `Valid <= 1`, `Done = 1`.
  - The next state is IDLE unconditionally.
  - A `Record` fall during DONE does not cancel the update.
- **Re-arming:** a new rise is required for the next capture. Holding `Record` high after DONE does not restart capture.
- **Output stability:** `Rec_WT` changes only in DONE, so the downstream synth never sees a partially filled table.
- **Reset mid-operation:** all state returns to the reset values immediately, including the synchronisers, `cnt` and `sh`.

## Timing
- **Start latency:** `Record` is sampled high at edge N. Then `rec_s` is high after edge N+1 and the rise is detected in the following cycle. `Busy` rises after edge N+2 (CAPTURE entered).
- **Sample points:**
  - Bit k (k = 0..31) is shifted at CAPTURE cycle k·`DIV` + `DIV`/2 − 1, counting from the first CAPTURE cycle as 0.
  - `bit_s` lags `BitIn` by 2 cycles.
  - `BitIn` must be stable from 3 cycles before each sample point through the sample point.
- **Completion:**
  - CAPTURE lasts exactly 32·`DIV` cycles.
  - DONE is the next cycle; `Done` is high during it.
  - `Rec_WT` and `Valid` are new from the edge that ends DONE.
  - `Busy` is low in DONE.
- **Abort latency:** `Record` falls at edge M. `Busy` is low after edge M+2; no `Done` pulse is produced.

## Configuration
- **`WT_REC_MAJORITY_EN` defined:**
  - Each shifted bit is the majority of `bit_s` at `cnt == DIV/2-2`, `DIV/2-1` and `DIV/2`.
  - The shift happens at `cnt == DIV/2`, and `BitIdx` increments there.
  - CAPTURE length is unchanged.
  - A single-cycle glitch on `BitIn` is rejected.
- **Not defined:** a single sample is taken at `cnt == DIV/2-1`, as in Operation.

## Test plan
All scenarios use `DIV`=8.
- **Basic capture:** reset, then raise `Record` and drive `BitIn` MSB-first with 32'h1377EEC8, 8 cycles per bit, aligned to CAPTURE entry. Expect `Rec_WT`=32'h1377EEC8, `Valid`=1, exactly one `Done` pulse, and `Busy` high for 256 cycles.
- **Reset defaults:** after reset, check `Rec_WT`=32'hFF00FF00, `Valid`=0, `Done`=0, `Busy`=0, `BitIdx`=0. Assert `RST` during bit 10 of a capture: expect the same values immediately and no `Done`.
- **Abort:** complete a capture of 32'hA5A5A5A5, then start a second capture with all-ones and drop `Record` at bit 20. Expect `Busy` low 2 cycles after the fall, `Rec_WT` still 32'hA5A5A5A5, and no `Done`.
- **No auto-restart:** hold `Record` high through and after completion for 600 cycles. Expect exactly one `Done` and `Busy` low after DONE. Then lower `Record` and raise it again: a new capture starts 3 cycles later.
- **Glitch filter:** with `BitIn`=0 for all bits except a 1-cycle high pulse at a sample point of bit 5:
  - `WT_REC_MAJORITY_EN` defined: expect `Rec_WT`=32'h00000000.
  - Not defined: expect `Rec_WT`=32'h04000000.
- **Boundary:** at `BitIdx`=32, drop `Record` so that `rec_s` goes low on the last CAPTURE cycle (`cnt`=7). Expect abort: no `Done`, and `Rec_WT` unchanged.
